// File: rtl/conv_row_sequencer_pkg.sv
// Shared constants, state encoding and size helpers for the convolution row sequencer.
// The sizes depend on the top-level parameters, so they are computed by constant functions.
package conv_row_sequencer_pkg;

  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int calc_out_h(input int h, input int f);
    return h - f + 1;
  endfunction

  function automatic int calc_out_w(input int w, input int f);
    return w - f + 1;
  endfunction

  function automatic int calc_half(input int w, input int f);
    return (w - f + 1) / 2;
  endfunction

  function automatic int calc_nstep(input int h, input int f);
    return 2 * (h - f + 1);
  endfunction

endpackage

// File: rtl/conv_row_sequencer_rf_index_counter.sv
// Row / half-column index pair for the receptive-field selector.
// Walks left half then right half of each output row; last flags the final position.
module rf_index_counter
  import conv_row_sequencer_pkg::*;
#(
  parameter int OUT_H = 6
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] row,
  output logic             col,
  output logic             last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= 1'b0;
    end else if (clear) begin
      row <= '0;
      col <= 1'b0;
    end else if (advance) begin
      if (!col) begin
        col <= 1'b1;
      end else begin
        col <= 1'b0;
        row <= row + IDX_W'(1);
      end
    end
  end

  assign last = col && (row == IDX_W'(OUT_H - 1));

endmodule

// File: rtl/conv_row_sequencer.sv
// Steps the selector over every output position, handshakes one half-row of results
// per position and assembles them into a flat row-major feature map.
module conv_row_sequencer
  import conv_row_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
)(
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  output logic [IDX_W-1:0]                                        rowNumber,
  output logic [IDX_W-1:0]                                        column,
  output logic                                                    rf_valid,
  input  logic [0:calc_half(W, F)*DATA_WIDTH-1]                   res_in,
  input  logic                                                    res_valid,
  output logic [0:calc_out_h(H, F)*calc_out_w(W, F)*DATA_WIDTH-1] fmap,
  output logic                                                    busy,
  output logic                                                    done
);

  localparam int OUT_H = calc_out_h(H, F);
  localparam int OUT_W = calc_out_w(W, F);
  localparam int HALF  = calc_half(W, F);

  generate
    if ((OUT_W % 2) != 0 || OUT_W < 2 || OUT_H < 1 || OUT_H > 64) begin : g_bad_params
      $error("conv_row_sequencer: W-F+1 must be even and 1 <= H-F+1 <= 64");
    end
  endgenerate

  state_t           state;
  logic [IDX_W-1:0] row;
  logic             col;
  logic             last;
  logic             clear;
  logic             advance;
  int               wr_base;

  // Indices restart on an accepted start and on the way back to idle; they only move
  // in STEP, so they are stable for the whole time rf_valid is high.
  always_comb begin
    clear   = (state == S_IDLE && start) || (state == S_DONE);
    advance = (state == S_STEP) && !last;
    wr_base = (int'(row) * OUT_W + int'(col) * HALF) * DATA_WIDTH;
  end

  rf_index_counter #(
    .OUT_H (OUT_H)
  ) u_index (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  assign rowNumber = row;
  assign column    = {{(IDX_W-1){1'b0}}, col};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rf_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fmap     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_REQ;
            rf_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_REQ: begin
          if (res_valid) begin
            fmap[wr_base +: HALF*DATA_WIDTH] <= res_in;
            rf_valid <= 1'b0;
            state    <= S_STEP;
          end
        end
        S_STEP: begin
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_REQ;
            rf_valid <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Randomized self-checking bench: small 8x8/F=3 instance plus a default-size instance,
// both checked against an array model of the feature map and the handshake order.
module tb_conv_row_sequencer;

  localparam int DW    = 16;
  localparam int SOH   = 6;
  localparam int SOW   = 6;
  localparam int SHALF = 3;
  localparam int BOH   = 28;
  localparam int BOW   = 28;
  localparam int BHALF = 14;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     resValid;
  logic [0:SHALF*DW-1]      resIn;
  logic [5:0]               rowNumber;
  logic [5:0]               column;
  logic                     rfValid;
  logic [0:SOH*SOW*DW-1]    fmap;
  logic                     busy;
  logic                     done;

  logic                     bigStart;
  logic                     bigResValid;
  logic [0:BHALF*DW-1]      bigResIn;
  logic [5:0]               bigRowNumber;
  logic [5:0]               bigColumn;
  logic                     bigRfValid;
  logic [0:BOH*BOW*DW-1]    bigFmap;
  logic                     bigBusy;
  logic                     bigDone;

  logic [15:0] model    [SOH*SOW];
  logic [15:0] bigModel [BOH*BOW];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_row_sequencer #(.DATA_WIDTH(DW), .H(8), .W(8), .F(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rowNumber (rowNumber),
    .column    (column),
    .rf_valid  (rfValid),
    .res_in    (resIn),
    .res_valid (resValid),
    .fmap      (fmap),
    .busy      (busy),
    .done      (done)
  );

  conv_row_sequencer #(.DATA_WIDTH(DW), .H(32), .W(32), .F(5)) dutBig (
    .clk       (clk),
    .reset     (reset),
    .start     (bigStart),
    .rowNumber (bigRowNumber),
    .column    (bigColumn),
    .rf_valid  (bigRfValid),
    .res_in    (bigResIn),
    .res_valid (bigResValid),
    .fmap      (bigFmap),
    .busy      (bigBusy),
    .done      (bigDone)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int fmapErrors();
    int n = 0;
    for (int i = 0; i < SOH*SOW; i++)
      if (fmap[i*DW +: DW] !== model[i]) n++;
    return n;
  endfunction

  function automatic int bigFmapErrors();
    int n = 0;
    for (int i = 0; i < BOH*BOW; i++)
      if (bigFmap[i*DW +: DW] !== bigModel[i]) n++;
    return n;
  endfunction

  // One run on the small instance: handshake order and map contents come from the model,
  // run length is 26 cycles plus every cycle the bench withheld res_valid in REQ.
  task automatic applyStimulus(input bit tieHigh, input bit pattern, input int stallStep,
                               input int resetStep, input bit spurious, input bit tailCheck);
    int step      = 0;
    int cnt       = 1;
    int stalls    = 0;
    int stallLeft = 7;
    int doneSeen  = 0;
    logic [15:0] v;
    @(posedge clk); #1;
    start    = 1'b1;
    resValid = spurious | tieHigh;
    for (int k = 0; k < SHALF; k++) resIn[k*DW +: DW] = 16'($urandom);
    while (cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      start    = 1'b0;
      resValid = 1'b0;
      if (done) begin
        doneSeen++;
        checkOutput("busyAtDone", int'(busy), 1);
        break;
      end
      if (rfValid) begin
        checkOutput("rowIndex", int'(rowNumber), step / 2);
        checkOutput("colIndex", int'(column), step % 2);
        if (step == resetStep) begin
          reset = 1'b1;
          #1;
          for (int i = 0; i < SOH*SOW; i++) model[i] = '0;
          checkOutput("rstRow", int'(rowNumber), 0);
          checkOutput("rstCol", int'(column), 0);
          checkOutput("rstRfValid", int'(rfValid), 0);
          checkOutput("rstBusy", int'(busy), 0);
          checkOutput("rstDone", int'(done), 0);
          checkOutput("rstFmap", fmapErrors(), 0);
          #2 reset = 1'b0;
          return;
        end
        if (step == stallStep && stallLeft > 0) begin
          stallLeft--;
          stalls++;
          if (stallLeft == 0) checkOutput("fmapStall", fmapErrors(), 0);
        end else if (tieHigh || $urandom_range(0, 3) != 0) begin
          resValid = 1'b1;
          for (int k = 0; k < SHALF; k++) begin
            v = pattern ? 16'((step / 2) * 16 + (step % 2) * 8 + k) : 16'($urandom);
            resIn[k*DW +: DW] = v;
            model[(step / 2) * SOW + (step % 2) * SHALF + k] = v;
          end
          step++;
        end else begin
          stalls++;
        end
      end else begin
        if (tieHigh) resValid = 1'b1;
        if (spurious) begin
          resValid = 1'($urandom_range(0, 1));
          start    = 1'($urandom_range(0, 1));
          for (int k = 0; k < SHALF; k++) resIn[k*DW +: DW] = 16'($urandom);
        end
      end
    end
    resValid = 1'b0;
    start    = 1'b0;
    checkOutput("doneReached", doneSeen, 1);
    checkOutput("runLength", cnt, 26 + stalls);
    checkOutput("fmapRun", fmapErrors(), 0);
    if (tailCheck) begin
      for (int t = 0; t < 4; t++) begin
        @(posedge clk); #1;
        if (t == 0) checkOutput("busyFall", int'(busy), 0);
        if (done) doneSeen++;
      end
      checkOutput("donePulses", doneSeen, 1);
    end
  endtask

  task automatic runBig();
    int cnt = 1;
    int step = 0;
    int maxRow = 0;
    int hits = 0;
    int doneSeen = 0;
    @(posedge clk); #1;
    bigStart    = 1'b1;
    bigResValid = 1'b1;
    while (cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      bigStart = 1'b0;
      if (bigDone) begin
        doneSeen = 1;
        break;
      end
      if (bigRfValid) begin
        if (int'(bigRowNumber) > maxRow) maxRow = int'(bigRowNumber);
        if (bigRowNumber == 6'd27 && bigColumn == 6'd1) hits++;
        for (int k = 0; k < BHALF; k++) begin
          bigResIn[k*DW +: DW] = 16'($urandom);
          bigModel[(step / 2) * BOW + (step % 2) * BHALF + k] = bigResIn[k*DW +: DW];
        end
        step++;
      end
    end
    bigResValid = 1'b0;
    checkOutput("bigDone", doneSeen, 1);
    checkOutput("bigRunLength", cnt, 114);
    checkOutput("bigMaxRow", maxRow, 27);
    checkOutput("bigLastPos", hits, 1);
    checkOutput("bigFmap", bigFmapErrors(), 0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    resValid    = 1'b0;
    resIn       = '0;
    bigStart    = 1'b0;
    bigResValid = 1'b0;
    bigResIn    = '0;
    for (int i = 0; i < SOH*SOW; i++) model[i] = '0;
    for (int i = 0; i < BOH*BOW; i++) bigModel[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("initRow", int'(rowNumber), 0);
    checkOutput("initCol", int'(column), 0);
    checkOutput("initRfValid", int'(rfValid), 0);
    checkOutput("initBusy", int'(busy), 0);
    checkOutput("initDone", int'(done), 0);
    checkOutput("initFmap", fmapErrors(), 0);
    checkOutput("initBigFmap", bigFmapErrors(), 0);
    #2 reset = 1'b0;

    $display("[TB] full run with res_valid tied high");
    applyStimulus(1'b1, 1'b1, -1, -1, 1'b0, 1'b1);
    for (int r = 0; r < SOH; r++)
      for (int c = 0; c < SOW; c++)
        checkOutput("patElem", int'(fmap[(r*SOW + c)*DW +: DW]), r*16 + (c/3)*8 + c%3);

    $display("[TB] stall at row 3 col 0 with spurious inputs");
    applyStimulus(1'b1, 1'b0, 6, -1, 1'b1, 1'b1);

    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      resValid = 1'b1;
      for (int k = 0; k < SHALF; k++) resIn[k*DW +: DW] = 16'($urandom);
    end
    @(posedge clk); #1;
    resValid = 1'b0;
    checkOutput("idleResValid", fmapErrors(), 0);

    $display("[TB] back-to-back random runs");
    applyStimulus(1'b0, 1'b0, -1, -1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, -1, -1, 1'b0, 1'b1);

    $display("[TB] reset mid-run then restart");
    applyStimulus(1'b0, 1'b0, -1, 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, -1, -1, 1'b0, 1'b1);

    $display("[TB] default-size instance");
    runBig();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
